bitwise_seq: RTL and testbench

BITWISE_SEQ -- requirements
Module: bitwise_seq

---
 rtl/bitwise_pkg.sv | 23 ++
 rtl/piso_shift.sv | 30 +++
 rtl/bitwise_seq.sv | 165 ++++++++++++++++
 tb/tb_bitwise_seq.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bitwise_pkg.sv
// Shared encodings for the bit-serial logic sequencer: operation codes, FSM states
// and the parity helper used when BITWISE_SEQ_PARITY_EN is defined.
package bitwise_pkg;

  typedef enum logic [1:0] {
    OP_NAND = 2'd0,
    OP_AND  = 2'd1,
    OP_OR   = 2'd2,
    OP_XOR  = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Even parity: 1 when the vector holds an odd number of ones.
  function automatic logic even_parity(input logic [31:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-in serial-out operand register: parallel load, right shift, bit 0 presented on q.
module piso_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             q
);

  logic [WIDTH-1:0] sr_r;

  // Operand register: load wins over shift; reset clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_r <= {WIDTH{1'b0}};
    end else if (load) begin
      sr_r <= d;
    end else if (shift) begin
      sr_r <= {1'b0, sr_r[WIDTH-1:1]};
    end else begin
      sr_r <= sr_r;
    end
  end

  assign q = sr_r[0];

endmodule

// File: rtl/bitwise_seq.sv
// Bit-serial sequencer that streams two operands LSB first through an external logic unit
// and reassembles its result. Defining BITWISE_SEQ_PARITY_EN adds the result_par output.
module bitwise_seq
  import bitwise_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             a,
  output logic             b,
  output logic             sel_1,
  output logic             sel_0,
  input  logic             c,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
`ifdef BITWISE_SEQ_PARITY_EN
  ,
  output logic             result_par
`endif
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  state_t           state_r;
  state_t           state_next_s;
  logic             load_s;
  logic             shift_s;
  logic [CNT_W-1:0] cnt_r;
  op_t              op_r;
  logic [WIDTH-1:0] result_r;
  logic [WIDTH-1:0] result_next_s;
  logic             a_q_s;
  logic             b_q_s;

  piso_shift #(.WIDTH(WIDTH)) u_a_shift (
    .clk   (clk),
    .rst   (rst),
    .load  (load_s),
    .shift (shift_s),
    .d     (a_in),
    .q     (a_q_s)
  );

  piso_shift #(.WIDTH(WIDTH)) u_b_shift (
    .clk   (clk),
    .rst   (rst),
    .load  (load_s),
    .shift (shift_s),
    .d     (b_in),
    .q     (b_q_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; start only matters in IDLE, so a request during an operation is dropped.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    shift_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          load_s       = 1'b1;
          state_next_s = ST_SHIFT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        shift_s = 1'b1;
        if (cnt_r == CNT_MAX) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // The first returned bit ends up in bit 0 after WIDTH shifts.
  assign result_next_s = {c, result_r[WIDTH-1:1]};

  // Counter, op latch and result assembly; result only moves while shifting.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r    <= {CNT_W{1'b0}};
      op_r     <= OP_NAND;
      result_r <= {WIDTH{1'b0}};
    end else if (load_s) begin
      cnt_r    <= {CNT_W{1'b0}};
      op_r     <= op_t'(op_in);
      result_r <= result_r;
    end else if (shift_s) begin
      cnt_r    <= cnt_r + CNT_W'(1);
      op_r     <= op_r;
      result_r <= result_next_s;
    end else begin
      cnt_r    <= cnt_r;
      op_r     <= op_r;
      result_r <= result_r;
    end
  end

`ifdef BITWISE_SEQ_PARITY_EN
  logic result_par_r;

  // Parity tracks the value being written into result so the two never disagree.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_par_r <= 1'b0;
    end else if (shift_s) begin
      result_par_r <= even_parity(32'(result_next_s));
    end else begin
      result_par_r <= result_par_r;
    end
  end

  assign result_par = result_par_r;
`endif

  // Interface to the logic unit is quiet outside SHIFT; status decodes the state register.
  always_comb begin
    a     = 1'b0;
    b     = 1'b0;
    sel_1 = 1'b0;
    sel_0 = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    if (state_r == ST_SHIFT) begin
      a     = a_q_s;
      b     = b_q_s;
      sel_1 = op_r[1];
      sel_0 = op_r[0];
      busy  = 1'b1;
    end else if (state_r == ST_DONE) begin
      busy  = 1'b1;
      done  = 1'b1;
    end else begin
      busy  = 1'b0;
    end
  end

  assign result = result_r;

endmodule

// File: tb/tb_bitwise_seq.sv
// Self-checking bench for bitwise_seq (WIDTH=8) with a behavioural model of the logic unit
// and of the expected sequencer timing; BITWISE_SEQ_PARITY_EN enables the parity checks.
module tb_bitwise_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op_in;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         a;
  logic         b;
  logic         sel_1;
  logic         sel_0;
  logic         c;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
`ifdef BITWISE_SEQ_PARITY_EN
  logic         result_par;
`endif

  int vectors     = 0;
  int miscompares = 0;

  bitwise_seq #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op_in  (op_in),
    .a_in   (a_in),
    .b_in   (b_in),
    .a      (a),
    .b      (b),
    .sel_1  (sel_1),
    .sel_0  (sel_0),
    .c      (c),
    .busy   (busy),
    .done   (done),
    .result (result)
`ifdef BITWISE_SEQ_PARITY_EN
    ,
    .result_par (result_par)
`endif
  );

  always #5 clk = ~clk;

  // External logic unit
  always_comb begin
    case ({sel_1, sel_0})
      2'd0:    c = ~(a & b);
      2'd1:    c = a & b;
      2'd2:    c = a | b;
      default: c = a ^ b;
    endcase
  end

  function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    case (op)
      2'd0:    return ~(x & y);
      2'd1:    return x & y;
      2'd2:    return x | y;
      default: return x ^ y;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model: m_t counts edges since the accepted start; operation occupies t=0..W (W = done cycle)
  bit           m_active = 1'b0;
  int           m_t      = 0;
  logic [W-1:0] m_a      = '0;
  logic [W-1:0] m_b      = '0;
  logic [1:0]   m_op     = 2'd0;
  logic [W-1:0] m_exp    = '0;
  logic [W-1:0] m_held   = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0;
      m_t      = 0;
      m_held   = '0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1;
        m_t      = 0;
        m_a      = a_in;
        m_b      = b_in;
        m_op     = op_in;
        m_exp    = ref_op(op_in, a_in, b_in);
      end
    end else begin
      m_t = m_t + 1;
      if (m_t == W) m_held = m_exp;
      if (m_t == W + 1) m_active = 1'b0;
    end
  end

  // Compare process
  always @(negedge clk) begin
    bit sh;
    sh = m_active && (m_t < W);
    check("busy", busy, m_active);
    check("done", done, m_active && (m_t == W));
    check("a", a, sh ? m_a[m_t] : 1'b0);
    check("b", b, sh ? m_b[m_t] : 1'b0);
    check("sel", {sel_1, sel_0}, sh ? m_op : 2'd0);
    if (!m_active || m_t == W) begin
      check("result", result, m_held);
`ifdef BITWISE_SEQ_PARITY_EN
      check("result_par", result_par, ^m_held);
`endif
    end
  end

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] op,
                        input bit repulse, output logic [W-1:0] res, output int cyc, output int dones);
    res   = '0;
    dones = 0;
    @(negedge clk);
    a_in = x; b_in = y; op_in = op; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      cyc++;
      if (done) begin
        dones++;
        res = result;
      end
      if (repulse && i == 2) begin
        a_in = 8'hFF; b_in = 8'h00; op_in = 2'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("op_timeout", busy, 1'b0);
  endtask

  logic [W-1:0] res;
  int           cyc;
  int           dones;

  initial begin
    rst = 1'b1; start = 1'b0; op_in = 2'd0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 8'h00);
    check("rst_abs", {a, b, sel_1, sel_0}, 4'h0);
    rst = 1'b0;

    run_op(8'hF0, 8'hCC, 2'd3, 1'b0, res, cyc, dones);
    check("xor_result", res, 8'h3C);
    check("xor_cycles", cyc, 10);
    check("xor_dones", dones, 1);
`ifdef BITWISE_SEQ_PARITY_EN
    check("par_3c", result_par, 1'b0);
`endif
    run_op(8'hF0, 8'hCC, 2'd0, 1'b0, res, cyc, dones);
    check("nand_result", res, 8'h3F);
    run_op(8'hF0, 8'hCC, 2'd1, 1'b0, res, cyc, dones);
    check("and_result", res, 8'hC0);
    run_op(8'hF0, 8'hCC, 2'd2, 1'b0, res, cyc, dones);
    check("or_result", res, 8'hFC);

    run_op(8'hF0, 8'hCC, 2'd3, 1'b1, res, cyc, dones);
    check("repulse_result", res, 8'h3C);
    check("repulse_cycles", cyc, 10);
    @(negedge clk);
    check("repulse_hold", result, 8'h3C);

    run_op(8'hC1, 8'hFF, 2'd1, 1'b0, res, cyc, dones);
    check("and_c1", res, 8'hC1);
`ifdef BITWISE_SEQ_PARITY_EN
    check("par_c1", result_par, 1'b1);
`endif

    // Abort mid-SHIFT at bit 4
    @(negedge clk);
    a_in = 8'hF0; b_in = 8'hCC; op_in = 2'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_result", result, 8'h00);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    check("abort_no_done", dones, 0);

    // start and rst together
    a_in = 8'hAA; b_in = 8'h55; op_in = 2'd2; start = 1'b1; rst = 1'b1;
    @(negedge clk);
    check("rst_start_busy", busy, 1'b0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_start_idle", busy, 1'b0);

    for (int n = 0; n < 30; n++) begin
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic [1:0]   op;
      x  = W'($urandom);
      y  = W'($urandom);
      op = 2'($urandom_range(0, 3));
      run_op(x, y, op, ($urandom_range(0, 3) == 0), res, cyc, dones);
      check("rand_result", res, ref_op(op, x, y));
      check("rand_dones", dones, 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
